csr_trap_unit: RTL and testbench



---
 rtl/riscv_csr_pkg.sv | 51 +++++
 rtl/csr_counter64.sv | 24 ++
 rtl/csr_trap_unit.sv | 177 +++++++++++++++++
 tb/tb_csr_trap_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/riscv_csr_pkg.sv
// Machine-mode CSR addresses, write-op encoding and field positions shared by
// the CSR/trap block and its counters.
package riscv_csr_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;
   localparam logic [11:0] CSR_MIMPID    = 12'hF13;

   typedef enum logic [1:0] {
      CSR_WRITE = 2'd0,
      CSR_SET   = 2'd1,
      CSR_CLEAR = 2'd2,
      CSR_NOP   = 2'd3
   } csr_op_e;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MSTATUS_MPP  = 11;

   localparam int MIP_MSIP = 3;
   localparam int MIP_MTIP = 7;
   localparam int MIP_MEIP = 11;

   localparam logic [31:0] MIE_MASK     = 32'h0000_0888;
   localparam logic [31:0] MSTATUS_MASK = 32'h0000_0088;

   function automatic logic [31:0] csr_apply(input csr_op_e op,
                                             input logic [31:0] q,
                                             input logic [31:0] d);
      case (op)
         CSR_WRITE: return d;
         CSR_SET:   return q | d;
         CSR_CLEAR: return q & ~d;
         default:   return q;
      endcase
   endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable halves; a write
// to either half takes precedence over the increment in that cycle.
module csr_counter64 (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        inc_i,
   input  logic        wr_lo_v_i,
   input  logic        wr_hi_v_i,
   input  logic [31:0] data_i,
   output logic [63:0] cnt_o
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt_o <= '0;
      else if (wr_lo_v_i)
         cnt_o[31:0] <= data_i;
      else if (wr_hi_v_i)
         cnt_o[63:32] <= data_i;
      else if (inc_i)
         cnt_o <= cnt_o + 64'd1;
   end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file: CSR read/write port, trap entry / MRET sequencing,
// interrupt pending generation and optional 64-bit cycle/instret counters.
module csr_trap_unit
   import riscv_csr_pkg::*;
#(
   parameter int              XLEN          = 32,
   parameter logic [XLEN-1:0] MVENDORID_VAL = 32'h0,
   parameter logic [XLEN-1:0] MARCHID_VAL   = 32'h0,
   parameter logic [XLEN-1:0] MIMPID_VAL    = 32'h0,
   parameter logic [XLEN-1:0] MISA_VAL      = 32'h4000_0100,
   parameter bit              HAS_COUNTERS  = 1'b1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [11:0]     rd_adr_i,
   output logic [XLEN-1:0] rd_data_o,
   output logic            rd_illegal_o,
   input  logic            wr_v_i,
   input  logic [11:0]     wr_adr_i,
   input  logic [1:0]      wr_op_i,
   input  logic [XLEN-1:0] wr_data_i,
   output logic            wr_illegal_o,
   input  logic            trap_v_i,
   input  logic [XLEN-1:0] trap_cause_i,
   input  logic [XLEN-1:0] trap_pc_i,
   input  logic [XLEN-1:0] trap_tval_i,
   input  logic            mret_v_i,
   input  logic            instret_v_i,
   input  logic            irq_sw_i,
   input  logic            irq_timer_i,
   input  logic            irq_ext_i,
   output logic            irq_pending_o,
   output logic [XLEN-1:0] trap_target_o,
   output logic [XLEN-1:0] mepc_o
);

   logic            mst_mie, mst_mpie;
   logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
   logic [2:0]      irq_q;
   logic [63:0]     mcycle, minstret;
   logic [XLEN-1:0] mstatus_rd, mip_rd;
   logic [XLEN:0]   rd_res, wr_res;
   logic [XLEN-1:0] wr_n;
   logic            wr_en;

   always_comb begin
      mstatus_rd                     = '0;
      mstatus_rd[MSTATUS_MPP+:2]     = 2'b11;
      mstatus_rd[MSTATUS_MPIE]       = mst_mpie;
      mstatus_rd[MSTATUS_MIE]        = mst_mie;
      mip_rd                         = '0;
      mip_rd[MIP_MSIP]               = irq_q[0];
      mip_rd[MIP_MTIP]               = irq_q[1];
      mip_rd[MIP_MEIP]               = irq_q[2];
   end

   // Result packs {illegal, data}; data is forced to 0 for illegal addresses.
   function automatic logic [XLEN:0] csr_read(input logic [11:0] adr);
      logic [XLEN-1:0] d;
      logic            ill;
      d   = '0;
      ill = 1'b0;
      case (adr)
         CSR_MSTATUS:   d = mstatus_rd;
         CSR_MISA:      d = MISA_VAL;
         CSR_MIE:       d = mie_q;
         CSR_MTVEC:     d = mtvec_q;
         CSR_MSCRATCH:  d = mscratch_q;
         CSR_MEPC:      d = mepc_q;
         CSR_MCAUSE:    d = mcause_q;
         CSR_MTVAL:     d = mtval_q;
         CSR_MIP:       d = mip_rd;
         CSR_MVENDORID: d = MVENDORID_VAL;
         CSR_MARCHID:   d = MARCHID_VAL;
         CSR_MIMPID:    d = MIMPID_VAL;
         CSR_MCYCLE:    begin d = mcycle[31:0];    ill = !HAS_COUNTERS; end
         CSR_MCYCLEH:   begin d = mcycle[63:32];   ill = !HAS_COUNTERS; end
         CSR_MINSTRET:  begin d = minstret[31:0];  ill = !HAS_COUNTERS; end
         CSR_MINSTRETH: begin d = minstret[63:32]; ill = !HAS_COUNTERS; end
         default:       ill = 1'b1;
      endcase
      if (ill) d = '0;
      return {ill, d};
   endfunction

   function automatic logic csr_ro(input logic [11:0] adr);
      return adr inside {CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MISA, CSR_MIP};
   endfunction

   always_comb begin
      rd_res       = csr_read(rd_adr_i);
      wr_res       = csr_read(wr_adr_i);
      rd_data_o    = rd_res[XLEN-1:0];
      rd_illegal_o = rd_res[XLEN];
      wr_n         = csr_apply(csr_op_e'(wr_op_i), wr_res[XLEN-1:0], wr_data_i);
      wr_illegal_o = wr_v_i & (wr_res[XLEN] | csr_ro(wr_adr_i));
      wr_en        = wr_v_i & ~wr_illegal_o & (csr_op_e'(wr_op_i) != CSR_NOP)
                   & ~trap_v_i & ~mret_v_i;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mst_mie    <= 1'b0;
         mst_mpie   <= 1'b0;
         mie_q      <= '0;
         mtvec_q    <= '0;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
         irq_q      <= '0;
      end else begin
         irq_q <= {irq_ext_i, irq_timer_i, irq_sw_i};
         if (trap_v_i) begin
            mepc_q   <= {trap_pc_i[XLEN-1:2], 2'b00};
            mcause_q <= trap_cause_i;
            mtval_q  <= trap_tval_i;
            mst_mpie <= mst_mie;
            mst_mie  <= 1'b0;
         end else if (mret_v_i) begin
            mst_mie  <= mst_mpie;
            mst_mpie <= 1'b1;
         end else if (wr_en) begin
            case (wr_adr_i)
               CSR_MSTATUS: begin
                  mst_mie  <= wr_n[MSTATUS_MIE];
                  mst_mpie <= wr_n[MSTATUS_MPIE];
               end
               CSR_MIE:      mie_q      <= wr_n & MIE_MASK;
               // Reserved modes 10/11 leave MODE untouched; BASE always updates.
               CSR_MTVEC:    mtvec_q    <= {wr_n[XLEN-1:2], wr_n[1] ? mtvec_q[1:0] : wr_n[1:0]};
               CSR_MSCRATCH: mscratch_q <= wr_n;
               CSR_MEPC:     mepc_q     <= {wr_n[XLEN-1:2], 2'b00};
               CSR_MCAUSE:   mcause_q   <= wr_n;
               CSR_MTVAL:    mtval_q    <= wr_n;
               default: ;
            endcase
         end
      end
   end

   generate
      if (HAS_COUNTERS) begin : g_cnt
         csr_counter64 u_mcycle (
            .clk       (clk),
            .reset_n   (reset_n),
            .inc_i     (1'b1),
            .wr_lo_v_i (wr_en && wr_adr_i == CSR_MCYCLE),
            .wr_hi_v_i (wr_en && wr_adr_i == CSR_MCYCLEH),
            .data_i    (wr_n),
            .cnt_o     (mcycle)
         );
         csr_counter64 u_minstret (
            .clk       (clk),
            .reset_n   (reset_n),
            .inc_i     (instret_v_i),
            .wr_lo_v_i (wr_en && wr_adr_i == CSR_MINSTRET),
            .wr_hi_v_i (wr_en && wr_adr_i == CSR_MINSTRETH),
            .data_i    (wr_n),
            .cnt_o     (minstret)
         );
      end else begin : g_no_cnt
         assign mcycle   = '0;
         assign minstret = '0;
      end
   endgenerate

   always_comb begin
      trap_target_o = {mtvec_q[XLEN-1:2], 2'b00};
      if (mtvec_q[1:0] == 2'b01 && trap_cause_i[XLEN-1])
         trap_target_o = trap_target_o + {trap_cause_i[XLEN-3:0], 2'b00};
   end

   assign irq_pending_o = mst_mie & |(mie_q & mip_rd);
   assign mepc_o        = mepc_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed checks of csr_trap_unit: reset state, WARL masking, trap/MRET
// sequencing, interrupt pending, priority and 64-bit counter behaviour.
module tb_csr_trap_unit;
   import riscv_csr_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [11:0] rd_adr_i, wr_adr_i;
   logic [31:0] rd_data_o, wr_data_i;
   logic        rd_illegal_o, wr_v_i, wr_illegal_o;
   logic [1:0]  wr_op_i;
   logic        trap_v_i, mret_v_i, instret_v_i;
   logic [31:0] trap_cause_i, trap_pc_i, trap_tval_i;
   logic        irq_sw_i, irq_timer_i, irq_ext_i, irq_pending_o;
   logic [31:0] trap_target_o, mepc_o;

   int n_chk = 0;
   int n_err = 0;

   csr_trap_unit dut (
      .clk(clk), .reset_n(reset_n),
      .rd_adr_i(rd_adr_i), .rd_data_o(rd_data_o), .rd_illegal_o(rd_illegal_o),
      .wr_v_i(wr_v_i), .wr_adr_i(wr_adr_i), .wr_op_i(wr_op_i), .wr_data_i(wr_data_i),
      .wr_illegal_o(wr_illegal_o),
      .trap_v_i(trap_v_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
      .trap_tval_i(trap_tval_i), .mret_v_i(mret_v_i), .instret_v_i(instret_v_i),
      .irq_sw_i(irq_sw_i), .irq_timer_i(irq_timer_i), .irq_ext_i(irq_ext_i),
      .irq_pending_o(irq_pending_o), .trap_target_o(trap_target_o), .mepc_o(mepc_o)
   );

   always #50 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input string tag, input logic [11:0] adr, input logic [31:0] exp);
      rd_adr_i = adr;
      #1;
      chk(tag, rd_data_o, exp);
   endtask

   task automatic wr(input logic [11:0] adr, input logic [1:0] op, input logic [31:0] d);
      wr_v_i = 1'b1; wr_adr_i = adr; wr_op_i = op; wr_data_i = d;
      step();
      wr_v_i = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; rd_adr_i = '0; wr_adr_i = '0; wr_op_i = '0; wr_data_i = '0;
      wr_v_i = 0; trap_v_i = 0; mret_v_i = 0; instret_v_i = 0;
      trap_cause_i = '0; trap_pc_i = '0; trap_tval_i = '0;
      irq_sw_i = 0; irq_timer_i = 0; irq_ext_i = 0;
      step(); step();
      reset_n = 1'b1;

      // reset state and mcycle starting at 0
      rd("rst_mstatus", CSR_MSTATUS, 32'h1800);
      rd("rst_misa", CSR_MISA, 32'h4000_0100);
      rd("rst_mtvec", CSR_MTVEC, 32'h0);
      rd("rst_mcycle0", CSR_MCYCLE, 32'd0);
      chk("rst_pending", {31'b0, irq_pending_o}, 32'd0);
      chk("rst_mepc_o", mepc_o, 32'h0);
      step();
      rd("mcycle1", CSR_MCYCLE, 32'd1);
      step();
      rd("mcycle2", CSR_MCYCLE, 32'd2);
      rd_adr_i = 12'h7C0;
      #1;
      chk("unk_rd_ill", {31'b0, rd_illegal_o}, 32'd1);
      chk("unk_rd_data", rd_data_o, 32'd0);

      // mstatus WARL, read-only misa
      wr(CSR_MSTATUS, CSR_WRITE, 32'hFFFF_FFFF);
      rd("mst_all", CSR_MSTATUS, 32'h1888);
      wr(CSR_MSTATUS, CSR_CLEAR, 32'h8);
      rd("mst_clr", CSR_MSTATUS, 32'h1880);
      wr_v_i = 1; wr_adr_i = CSR_MISA; wr_op_i = CSR_WRITE; wr_data_i = 32'h0;
      #1;
      chk("misa_wr_ill", {31'b0, wr_illegal_o}, 32'd1);
      step(); wr_v_i = 0;
      rd("misa_keep", CSR_MISA, 32'h4000_0100);

      // mtvec mode WARL and vectored trap
      wr(CSR_MTVEC, CSR_WRITE, 32'h2002);
      rd("mtvec_badmode", CSR_MTVEC, 32'h2000);
      wr(CSR_MTVEC, CSR_WRITE, 32'h1001);
      rd("mtvec_vec", CSR_MTVEC, 32'h1001);
      wr(CSR_MSTATUS, CSR_SET, 32'h8);
      trap_cause_i = 32'h2; #1;
      chk("tgt_exc", trap_target_o, 32'h1000);
      trap_v_i = 1; trap_cause_i = 32'h8000_0007; trap_pc_i = 32'h203; trap_tval_i = 32'hDEAD;
      #1;
      chk("tgt_irq", trap_target_o, 32'h101C);
      step(); trap_v_i = 0;
      chk("trap_mepc", mepc_o, 32'h200);
      rd("trap_mcause", CSR_MCAUSE, 32'h8000_0007);
      rd("trap_mtval", CSR_MTVAL, 32'hDEAD);
      rd("trap_mst", CSR_MSTATUS, 32'h1880);

      // interrupt pending and MRET
      wr(CSR_MIE, CSR_WRITE, 32'hFFFF_FFFF);
      rd("mie_mask", CSR_MIE, 32'h888);
      wr(CSR_MIE, CSR_WRITE, 32'h80);
      wr(CSR_MSTATUS, CSR_SET, 32'h8);
      irq_timer_i = 1; #1;
      chk("pend_pre", {31'b0, irq_pending_o}, 32'd0);
      step();
      chk("pend_post", {31'b0, irq_pending_o}, 32'd1);
      rd("mip_timer", CSR_MIP, 32'h80);
      trap_v_i = 1; trap_cause_i = 32'h8000_0007; trap_pc_i = 32'h300;
      step(); trap_v_i = 0;
      chk("pend_in_trap", {31'b0, irq_pending_o}, 32'd0);
      mret_v_i = 1;
      step(); mret_v_i = 0;
      rd("mret_mst", CSR_MSTATUS, 32'h1888);
      chk("pend_mret", {31'b0, irq_pending_o}, 32'd1);
      irq_timer_i = 0;
      step();

      // priority: trap beats mret and write
      wr(CSR_MSCRATCH, CSR_WRITE, 32'h11);
      wr(CSR_MSCRATCH, CSR_NOP, 32'h0);
      rd("scr_nop", CSR_MSCRATCH, 32'h11);
      wr(CSR_MSCRATCH, CSR_SET, 32'h100);
      rd("scr_set", CSR_MSCRATCH, 32'h111);
      trap_v_i = 1; mret_v_i = 1; trap_cause_i = 32'h2; trap_pc_i = 32'h404; trap_tval_i = 32'h55;
      wr_v_i = 1; wr_adr_i = CSR_MSCRATCH; wr_op_i = CSR_WRITE; wr_data_i = 32'h5;
      #1;
      chk("prio_wr_ill", {31'b0, wr_illegal_o}, 32'd0);
      step(); trap_v_i = 0; mret_v_i = 0; wr_v_i = 0;
      rd("prio_mst", CSR_MSTATUS, 32'h1880);
      rd("prio_scr", CSR_MSCRATCH, 32'h111);
      chk("prio_mepc", mepc_o, 32'h404);
      wr(CSR_MEPC, CSR_WRITE, 32'h307);
      chk("mepc_align", mepc_o, 32'h304);

      // counters: carry lo->hi, write beats increment
      wr(CSR_MCYCLE, CSR_WRITE, 32'hFFFF_FFFF);
      rd("cyc_lo_wr", CSR_MCYCLE, 32'hFFFF_FFFF);
      rd("cyc_hi_wr", CSR_MCYCLEH, 32'h0);
      step();
      rd("cyc_lo_wrap", CSR_MCYCLE, 32'h0);
      rd("cyc_hi_carry", CSR_MCYCLEH, 32'h1);
      instret_v_i = 1;
      step(); instret_v_i = 0;
      rd("instret_inc", CSR_MINSTRET, 32'h1);
      instret_v_i = 1;
      wr(CSR_MINSTRETH, CSR_WRITE, 32'h1234);
      instret_v_i = 0;
      rd("instreth_wr", CSR_MINSTRETH, 32'h1234);
      rd("instret_noinc", CSR_MINSTRET, 32'h1);

      // asynchronous reset mid-cycle
      #10 reset_n = 1'b0;
      #1;
      rd("arst_mst", CSR_MSTATUS, 32'h1800);
      rd("arst_cych", CSR_MCYCLEH, 32'h0);
      chk("arst_mepc", mepc_o, 32'h0);
      reset_n = 1'b1;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
